// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - client-side request/response bundle for mult_arbiter
interface mult_arbiter_if #(
    parameter int width_p = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*width_p-1:0] req_multiplicand;
    logic [NUM_REQ*width_p-1:0] req_multiplier;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [2*width_p-1:0]       rsp_product;
    logic                       rsp_err;

    modport master (
        output req_valid, req_multiplicand, req_multiplier, rsp_ready,
        input  req_ready, rsp_valid, rsp_product, rsp_err
    );

    modport slave (
        input  req_valid, req_multiplicand, req_multiplier, rsp_ready,
        output req_ready, rsp_valid, rsp_product, rsp_err
    );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sequencer sharing one shift-add multiplier among NUM_REQ clients
module mult_arbiter #(
    parameter int width_p = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int OW = $clog2(NUM_REQ),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_arbiter_if.slave        client,
    output logic                 mult_reset_n,
    output logic                 mult_start,
    output logic [width_p-1:0]   mult_multiplicand,
    output logic [width_p-1:0]   mult_multiplier,
    input  logic                 mult_ready,
    input  logic                 mult_done,
    input  logic [2*width_p-1:0] mult_product,
    output logic [OW-1:0]        owner,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, state_nxt;
    logic [OW-1:0]        last_grant;
    logic [OW-1:0]        grant;
    logic [CW-1:0]        cnt;
    logic [2*width_p-1:0] result;
    logic                 err;
    logic                 accept;
    logic                 rsp_hs;
    logic                 timeout_hit;

    assign mult_reset_n       = ~reset;
    assign client.rsp_product = result;
    assign client.rsp_err     = err;

    // First requester at or after last_grant+1, wrapping around.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && client.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                grant = OW'((int'(last_grant) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign accept      = (state == IDLE) && mult_ready && (|client.req_valid);
    assign rsp_hs      = (state == RESP) && client.rsp_ready[owner];
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mult_done || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        client.req_ready = '0;
        client.rsp_valid = '0;
        if (accept) client.req_ready[grant] = 1'b1;
        if (state == RESP) client.rsp_valid[owner] = 1'b1;
        mult_start = (state == ISSUE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant        <= OW'(NUM_REQ - 1);
            owner             <= '0;
            cnt               <= '0;
            result            <= '0;
            err               <= 1'b0;
            mult_multiplicand <= '0;
            mult_multiplier   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner             <= grant;
                    mult_multiplicand <= client.req_multiplicand[grant*width_p +: width_p];
                    mult_multiplier   <= client.req_multiplier[grant*width_p +: width_p];
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A done arriving in the same cycle as the timeout still wins.
                    if (mult_done) begin
                        result <= mult_product;
                        err    <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                RESP: if (rsp_hs) last_grant <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one shift-add multiplier (the `multiplicand`/`multiplier`/`start`/`ready`/`product`/`done` unit) among `NUM_REQ` independent requesters. It accepts one operand pair at a time, drives a single-cycle `start` to the multiplier, captures the product on `done`, and returns it to the owning requester over a valid/ready response channel. It sits between the client ports and the multiplier and is the only driver of the multiplier's inputs.

## Interface
- `width_p`, 8, operand width; product is `2*width_p`
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max cycles in WAIT before abort
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set
- `req_multiplicand`  in  NUM_REQ*width_p  packed, requester i at `[i*width_p +: width_p]`
- `req_multiplier`  in  NUM_REQ*width_p  packed, same layout
- `rsp_valid`  out  NUM_REQ  result valid for requester i; at most one bit set
- `rsp_ready`  in  NUM_REQ  per-requester result accept
- `rsp_product`  out  2*width_p  shared result bus, meaningful where `rsp_valid` is set
- `rsp_err`  out  1  qualifies `rsp_valid`: result is a timeout abort
- `mult_reset_n`  out  1  multiplier reset, `= ~reset` (combinational)
- `mult_start`  out  1  one-cycle start pulse to multiplier
- `mult_multiplicand`, `mult_multiplier`  out  width_p  latched operands, stable from ISSUE until next accept
- `mult_ready`  in  1  multiplier idle and able to start
- `mult_done`  in  1  multiplier result valid
- `mult_product`  in  2*width_p  multiplier result
- `owner`  out  $clog2(NUM_REQ)  index of current grant
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `mult_ready` and any `req_valid`, grant `g` = first set `req_valid` bit searching from `(last_grant+1) mod NUM_REQ` upward with wrap. Assert `req_ready[g]` combinationally in this cycle, latch operands and `owner<=g`, go to ISSUE. If `mult_ready`=0, `req_ready`=0 and the FSM stays in IDLE.
- ISSUE: `mult_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: counter increments each cycle. On `mult_done`=1, latch `mult_product` into the result register, `rsp_err<=0`, go to RESP. If the counter reaches `TIMEOUT` first, load the result register with 0, `rsp_err<=1`, go to RESP. `mult_done` takes priority when both occur in the same cycle.
- RESP: `rsp_valid[owner]`=1 and `rsp_product` = result register, held stable until `rsp_ready[owner]`=1. On that handshake: `last_grant<=owner`, go to IDLE. `rsp_ready` bits of non-owners are ignored.
- `mult_done` outside WAIT is ignored. `req_valid` changes outside IDLE have no effect; requesters hold their operands until `req_ready`.
- Reset values: state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 has first priority), `owner`=0, result=0, `rsp_err`=0. All `req_ready`, `rsp_valid`, and `mult_start` are 0; `busy`=0; operand outputs are 0.
- Reset mid-operation, in any state: the in-flight operation is discarded with no response. `mult_reset_n`=0 for the reset cycles, so the multiplier is also reset.

## Timing
- Accept in cycle T (`req_valid[g]&req_ready[g]`) -> `mult_start` in T+1 -> `mult_done` in T+1+L, where L is the multiplier latency -> `rsp_valid[g]` from T+2+L.
- Response handshake in cycle R -> IDLE in R+1. The earliest next accept is R+1, so there is no dead cycle beyond the FSM.
- Timeout abort: `rsp_valid` rises `TIMEOUT`+1 cycles after ISSUE.
- `rsp_product`, `rsp_err`, and `owner` are registered and stable for the whole RESP state.

## Test plan
- Single request: reset, then requester 2 sends 8'd13 x 8'd11 -> `req_ready[2]` in the same cycle, one `mult_start`, `rsp_valid[2]` with `rsp_product`=16'd143 and `rsp_err`=0.
- Fairness: all four `req_valid` held high, each with distinct operands -> grant order 0,1,2,3,0,… and each product correct (e.g. 8'd255 x 8'd255 = 16'd65025).
- Response backpressure: hold `rsp_ready[owner]`=0 for 10 cycles -> `rsp_valid` and `rsp_product` stay stable, no new `req_ready`, no `mult_start`.
- Multiplier not ready: `mult_ready`=0 with `req_valid`=4'b0001 -> `req_ready`=0 until `mult_ready` rises, then accept in that same cycle.
- Timeout: stub holds `mult_done`=0 -> `rsp_valid[owner]` with `rsp_product`=0 and `rsp_err`=1 `TIMEOUT`+1 cycles after start; the next request completes normally.
- Reset in WAIT: assert `reset` for 1 cycle -> `busy`=0, `mult_reset_n`=0 in that cycle, no `rsp_valid`; the next grant goes to requester 0.
